// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and helpers for the MIPS-style HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

   // Magnitude of a two's complement operand; 0x80000000 maps to itself as unsigned.
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_restoring_step
   import muldiv_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0] shifted;
   logic [W:0] diff;

   assign shifted = {rem, quo[W-1]};
   // rem < divisor keeps shifted below 2*divisor, so diff[W] is the borrow.
   assign diff = shifted - {1'b0, divisor};
   assign rem_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
   assign quo_next = {quo[W-2:0], ~diff[W]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO/MFHI/MFLO access.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier on MULT/MULTU.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [5:0]      funct,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] Hi,
   output logic [XLEN-1:0] Lo,
   output logic [XLEN-1:0] rd_data
);
   import muldiv_pkg::*;

   state_t            state;
   logic [4:0]        cnt;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   raw_a;
   logic [2*XLEN-1:0] acc;
   logic              op_div;
   logic              dz;
   logic              neg_hi;
   logic              neg_lo;

   logic is_mul;
   logic is_div;
   logic is_sgn;
   logic accept;

   always_comb begin
      is_mul = 1'b0;
      is_div = 1'b0;
      is_sgn = 1'b0;
      unique case (funct)
         F_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
         F_MULTU: is_mul = 1'b1;
         F_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
         F_DIVU:  is_div = 1'b1;
         default: ;
      endcase
   end

   assign accept = start && (state == IDLE) && (is_mul || is_div);
   assign stall  = accept || (state == MUL) || (state == DIV) || (state == FIX);

   always_comb begin
      rd_data = '0;
      if (funct == F_MFHI)
         rd_data = Hi;
      else if (funct == F_MFLO)
         rd_data = Lo;
   end

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
   logic [XLEN:0]   mul_sum;
   logic [XLEN-1:0] rem_n;
   logic [XLEN-1:0] quo_n;

   assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);

   div_restoring_step #(.W(XLEN)) u_step (
      .rem      (acc[2*XLEN-1:XLEN]),
      .quo      (acc[XLEN-1:0]),
      .divisor  (mag_b),
      .rem_next (rem_n),
      .quo_next (quo_n)
   );

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;
   state_t            mul_next;

`ifdef MULDIV_FAST_MUL_EN
   assign prod     = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
   assign mul_next = FIX;
`else
   assign prod     = acc;
   assign mul_next = MUL;
`endif

   assign prod_s = neg_lo ? -prod : prod;
   assign quo_s  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   assign rem_s  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         raw_a  <= '0;
         acc    <= '0;
         op_div <= 1'b0;
         dz     <= 1'b0;
         neg_hi <= 1'b0;
         neg_lo <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (start && funct == F_MTHI)
                  Hi <= SrcA;
               if (start && funct == F_MTLO)
                  Lo <= SrcA;
               if (accept) begin
                  mag_a  <= mag(SrcA, is_sgn);
                  mag_b  <= mag(SrcB, is_sgn);
                  raw_a  <= SrcA;
                  op_div <= is_div;
                  dz     <= is_div && (SrcB == '0);
                  neg_lo <= is_sgn && (SrcA[XLEN-1] ^ SrcB[XLEN-1]);
                  neg_hi <= is_div && is_sgn && SrcA[XLEN-1];
                  if (is_div) begin
                     acc   <= {{XLEN{1'b0}}, mag(SrcA, is_sgn)};
                     state <= (SrcB == '0) ? FIX : DIV;
                  end else begin
                     acc   <= {{XLEN{1'b0}}, mag(SrcB, is_sgn)};
                     state <= mul_next;
                  end
               end
            end
            MUL: begin
               acc <= {mul_sum, acc[XLEN-1:1]};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31)
                  state <= FIX;
            end
            DIV: begin
               acc <= {rem_n, quo_n};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31)
                  state <= FIX;
            end
            FIX: begin
               if (!op_div) begin
                  Hi <= prod_s[2*XLEN-1:XLEN];
                  Lo <= prod_s[XLEN-1:0];
               end else if (dz) begin
                  Hi <= raw_a;
                  Lo <= '1;
               end else begin
                  Hi <= rem_s;
                  Lo <= quo_s;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, stall/done timing, results, reset and HI/LO moves.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        stall;
   logic        done;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic [31:0] rd_data;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .funct   (funct),
      .SrcA    (SrcA),
      .SrcB    (SrcB),
      .stall   (stall),
      .done    (done),
      .Hi      (Hi),
      .Lo      (Lo),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Issues one op in cycle 0 and follows it to its done pulse. Cycles inj_lo..inj_hi
   // carry a competing MULT start that the busy unit must ignore.
   task automatic run_op(input string tag, input bit wait_edge, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int inj_lo, input int inj_hi);
      int n;
      bit stall_ok;
      if (wait_edge)
         @(negedge clk);
      start = 1'b1;
      funct = f;
      SrcA  = a;
      SrcB  = b;
      #1;
      chk({tag, "_stall0"}, stall, 1);
      n = 0;
      stall_ok = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (n >= inj_lo && n <= inj_hi) begin
            start = 1'b1;
            funct = F_MULT;
            SrcA  = 32'd3;
            SrcB  = 32'd5;
         end else begin
            start = 1'b0;
            funct = 6'd0;
         end
         #1;
         if (!done && !stall)
            stall_ok = 1'b0;
      end while (!done && n < 60);
      chk({tag, "_cycle"}, n, lat);
      chk({tag, "_busy"}, stall_ok, 1);
      chk({tag, "_stall_done"}, stall, 0);
      chk({tag, "_hi"}, Hi, ehi);
      chk({tag, "_lo"}, Lo, elo);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      funct = 6'd0;
      SrcA  = '0;
      SrcB  = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", Hi, 0);
      chk("rst_lo", Lo, 0);
      reset = 1'b0;

      run_op("multu_max", 1, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT,
             32'hFFFFFFFE, 32'h00000001, 1, 0);
      run_op("mult_neg", 1, F_MULT, 32'hFFFFFFFD, 32'd7, MUL_LAT,
             32'hFFFFFFFF, 32'hFFFFFFEB, 1, 0);
      run_op("mult_min", 1, F_MULT, 32'h80000000, 32'h80000000, MUL_LAT,
             32'h40000000, 32'h00000000, 1, 0);
      run_op("div_neg", 1, F_DIV, 32'hFFFFFFF9, 32'd2, 34,
             32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0);
      run_op("divu_zero", 1, F_DIVU, 32'd5, 32'd0, 2,
             32'd5, 32'hFFFFFFFF, 1, 0);
      run_op("div_zero", 1, F_DIV, 32'hFFFFFFFB, 32'd0, 2,
             32'hFFFFFFFB, 32'hFFFFFFFF, 1, 0);
      run_op("div_ovf", 1, F_DIV, 32'h80000000, 32'hFFFFFFFF, 34,
             32'h00000000, 32'h80000000, 1, 0);
      run_op("divu_max", 1, F_DIVU, 32'hFFFFFFFF, 32'd1, 34,
             32'h00000000, 32'hFFFFFFFF, 1, 0);
      run_op("div_negb", 1, F_DIV, 32'd7, 32'hFFFFFFFE, 34,
             32'h00000001, 32'hFFFFFFFD, 1, 0);

      // Reset in cycle 10 of a DIV, then a DIVU started in the first cycle after release.
      @(negedge clk);
      start = 1'b1;
      funct = F_DIV;
      SrcA  = 32'd1000;
      SrcB  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_stall", stall, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", Hi, 0);
      chk("midrst_lo", Lo, 0);
      reset = 1'b0;
      run_op("divu_after_rst", 0, F_DIVU, 32'd100, 32'd7, 34,
             32'd2, 32'd14, 1, 0);

      run_op("div_inj", 1, F_DIV, 32'd1000, 32'hFFFFFFF9, 34,
             32'd6, 32'hFFFFFF72, 1, 33);
      run_op("multu_inj", 1, F_MULTU, 32'h12345678, 32'h10, MUL_LAT,
             32'h00000001, 32'h23456780, 1, MUL_LAT - 1);

      @(negedge clk);
      start = 1'b1;
      funct = F_MTHI;
      SrcA  = 32'h1234;
      #1;
      chk("mthi_stall", stall, 0);
      @(negedge clk);
      start = 1'b0;
      funct = F_MFHI;
      #1;
      chk("mfhi_data", rd_data, 32'h1234);
      chk("mfhi_stall", stall, 0);
      chk("mthi_done", done, 0);

      @(negedge clk);
      start = 1'b1;
      funct = F_MTLO;
      SrcA  = 32'h5678;
      #1;
      chk("mtlo_stall", stall, 0);
      @(negedge clk);
      start = 1'b0;
      funct = F_MFLO;
      #1;
      chk("mflo_data", rd_data, 32'h5678);
      chk("mtlo_hi_kept", Hi, 32'h1234);

      @(negedge clk);
      start = 1'b1;
      funct = 6'b100000;
      SrcA  = 32'hFFFF;
      SrcB  = 32'd1;
      #1;
      chk("bad_stall", stall, 0);
      chk("bad_rd", rd_data, 0);
      @(negedge clk);
      start = 1'b0;
      funct = 6'd0;
      #1;
      chk("bad_done", done, 0);
      chk("bad_hi", Hi, 32'h1234);
      chk("bad_lo", Lo, 32'h5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request qualifier for funct/SrcA/SrcB.
REQ-005 SHALL have port funct, input, 6, R-type function field selecting the operation.
REQ-006 SHALL have port SrcA, input, 32, dividend / multiplicand / MTHI-MTLO source.
REQ-007 SHALL have port SrcB, input, 32, divisor / multiplier.
REQ-008 SHALL have port stall, output, 1, pipeline hold while an operation is in flight.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when Hi/Lo hold a new mul/div result.
REQ-010 SHALL have port Hi, output, 32, HI register value.
REQ-011 SHALL have port Lo, output, 32, LO register value.
REQ-012 SHALL have port rd_data, output, 32, Hi for MFHI (010000), Lo for MFLO (010010), else 0; combinational.

Function
REQ-013 SHALL decode MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; any other funct with start SHALL be ignored.
REQ-014 SHALL use FSM states IDLE, MUL, DIV, FIX, DONE; only IDLE accepts start.
REQ-015 SHALL, for a mul/div start in IDLE (cycle 0), drive stall high combinationally in cycle 0 and latch operand magnitudes and result signs at the end of cycle 0.
REQ-016 SHALL iterate one bit per cycle for 32 cycles (cycles 1-32), using shift-add for MUL and restoring subtraction for DIV.
REQ-017 SHALL, in FIX (cycle 33), apply sign correction and write Hi/Lo at the end of the cycle.
REQ-018 SHALL be in DONE in cycle 34 with done=1 and stall=0, then return to IDLE.
REQ-019 SHALL produce the 64-bit product as {Hi,Lo}; signed for MULT, unsigned for MULTU.
REQ-020 SHALL set Lo=quotient and Hi=remainder; for DIV, quotient sign = sign(SrcA)^sign(SrcB), remainder sign = sign(SrcA), with truncation toward zero.
REQ-021 SHALL, on divide by zero, skip iteration and go IDLE->FIX->DONE (done in cycle 2), with Hi=SrcA and Lo=32'hFFFFFFFF.
REQ-022 SHALL produce Lo=32'h80000000 and Hi=0 for DIV 0x80000000 / 0xFFFFFFFF, with no trap.
REQ-023 SHALL write SrcA to Hi (MTHI) or Lo (MTLO) at the end of the start cycle when in IDLE, with no stall and no done.
REQ-024 SHALL ignore start while not in IDLE; operands and funct are not re-sampled.
REQ-025 SHALL leave Hi/Lo unchanged except in FIX or on MTHI/MTLO.

Reset
REQ-026 SHALL, on reset (including mid-operation), force state IDLE, Hi=0, Lo=0, stall=0, done=0, and clear iteration counter and datapath registers.
REQ-027 SHALL accept start in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with MULDIV_FAST_MUL_EN defined, compute MULT/MULTU with one single-cycle 32x32 multiplier (IDLE->FIX->DONE, done in cycle 2).
REQ-029 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiplier (done in cycle 34); divide timing is identical in both builds.

Structure
REQ-030 SHALL place the funct constants, the FSM state enum typedef and XLEN in a shared package muldiv_pkg.
REQ-031 SHALL implement the restoring divider step datapath as sub-module div_restoring_step; the multiplier iteration stays inline.

Verification
REQ-032 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 34, Hi=0xFFFFFFFE, Lo=0x00000001, stall high in cycles 0-33.
REQ-033 SHALL cover MULT -3 x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; with MULDIV_FAST_MUL_EN, done in cycle 2.
REQ-034 SHALL cover DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; and DIVU 5 / 0 -> done in cycle 2, Hi=5, Lo=0xFFFFFFFF.
REQ-035 SHALL cover reset asserted in cycle 10 of a DIV -> stall=0, Hi=Lo=0; then DIVU 100 / 7 -> Lo=14, Hi=2.
REQ-036 SHALL cover MTHI 0x1234, then MFHI -> rd_data=0x1234 in the next cycle, with stall never high.
REQ-037 SHALL cover a second MULT start during the busy cycles of a previous operation -> ignored, first result unchanged.
